// File: rtl/lc3b_types.sv
// Shared types for the Wishbone word port: controller state encoding and
// small elaboration-time helpers.
package lc3b_types;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUS     = 2'd1,
    BACKOFF = 2'd2
  } port_state_e;

  // Bit width needed to count 0..n-1, never below one bit.
  function automatic int min1_clog2(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/req_fifo.sv
// In-order request queue. Storage is read combinationally at the read
// pointer so the head entry is visible in the cycle right after it is written.
module req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full queue or a pop from an empty one is dropped.
  assign do_push = push && (count != CNT_W'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign dout    = mem[rd_ptr];

  // Entry storage needs no reset; count decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_word_port.sv
// Word-wide request port onto a line-wide Wishbone bus, with retry/backoff.
//
// state   | meaning
// IDLE    | queue empty, bus released
// BUS     | head request presented on the bus, waiting for ack or rty
// BACKOFF | one idle bus cycle after a rty before the same request retries
module wb_word_port
  import lc3b_types::*;
#(
  parameter int WORD_W    = 16,
  parameter int LINE_W    = 128,
  parameter int ADDR_W    = 16,
  parameter int DEPTH     = 2,
  parameter int MAX_RETRY = 3
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  req_valid,
  output logic                                  req_ready,
  input  logic                                  req_we,
  input  logic [ADDR_W-1:0]                     req_addr,
  input  logic [WORD_W-1:0]                     req_wdata,
  input  logic [WORD_W/8-1:0]                   req_be,
  output logic                                  rsp_valid,
  output logic [WORD_W-1:0]                     rsp_rdata,
  output logic                                  rsp_err,
  output logic [ADDR_W-$clog2(LINE_W/8)-1:0]    wb_adr,
  output logic [LINE_W-1:0]                     wb_dat_m,
  input  logic [LINE_W-1:0]                     wb_dat_s,
  output logic [LINE_W/8-1:0]                   wb_sel,
  output logic                                  wb_we,
  output logic                                  wb_stb,
  output logic                                  wb_cyc,
  input  logic                                  wb_ack,
  input  logic                                  wb_rty
);

  localparam int BYTES    = WORD_W / 8;
  localparam int SEL_W    = LINE_W / 8;
  localparam int BYTE_OFF = $clog2(BYTES);
  localparam int LINE_OFF = $clog2(SEL_W);
  localparam int IDX_W    = LINE_OFF - BYTE_OFF;
  localparam int ENT_W    = 1 + ADDR_W + WORD_W + BYTES;
  localparam int CNT_W    = $clog2(DEPTH) + 1;
  localparam int RTY_W    = min1_clog2(MAX_RETRY + 1);

  port_state_e       state;
  logic [CNT_W-1:0]  q_count;
  logic [ENT_W-1:0]  q_din;
  logic [ENT_W-1:0]  q_dout;
  logic              push;
  logic              pop;
  logic              in_bus;
  logic              final_try;
  logic              more;
  logic [RTY_W-1:0]  retry;

  logic              head_we;
  logic [ADDR_W-1:0] head_addr;
  logic [WORD_W-1:0] head_wdata;
  logic [BYTES-1:0]  head_be;
  logic [IDX_W-1:0]  idx;
  logic [31:0]       bit_sh;
  logic [31:0]       byte_sh;
  logic [WORD_W-1:0] rd_word;

  // Ready depends only on the registered occupancy, never on a same-cycle pop.
  assign req_ready = (q_count < CNT_W'(DEPTH));
  assign push      = req_valid && req_ready;
  assign q_din     = {req_we, req_addr, req_wdata, req_be};

  req_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_req_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (q_din),
    .dout  (q_dout),
    .count (q_count)
  );

  assign {head_we, head_addr, head_wdata, head_be} = q_dout;

  // Lane selection inside the line is taken from the head entry's address.
  assign idx     = head_addr[LINE_OFF-1:BYTE_OFF];
  assign bit_sh  = 32'(idx) * 32'(WORD_W);
  assign byte_sh = 32'(idx) * 32'(BYTES);

  assign in_bus    = (state == BUS);
  assign final_try = (retry == RTY_W'(MAX_RETRY));
  // A head leaves the queue on ack, or on a rty once the retry budget is spent.
  assign pop       = in_bus && (wb_ack || (wb_rty && final_try));
  // After a pop the bus stays busy if anything is left or arriving this edge.
  assign more      = (q_count > CNT_W'(1)) || push;

  assign wb_stb   = in_bus;
  assign wb_cyc   = in_bus;
  assign wb_we    = in_bus && head_we;
  assign wb_adr   = head_addr[ADDR_W-1:LINE_OFF];
  assign wb_sel   = in_bus ? (SEL_W'(head_be) << byte_sh) : '0;
  assign wb_dat_m = LINE_W'(head_wdata) << bit_sh;
  assign rd_word  = WORD_W'(wb_dat_s >> bit_sh);

  // Sub-word address bits select bytes via req_be, not the lane.
  if (BYTE_OFF > 0) begin : g_lsb
    logic unused_lsb;
    assign unused_lsb = ^head_addr[BYTE_OFF-1:0];
  end

  // Controller: bus sequencing, retry budget and the one-cycle response pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      retry     <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      case (state)
        IDLE: begin
          // A request accepted at this edge goes out on the very next cycle.
          if ((q_count != '0) || push) begin
            state <= BUS;
            retry <= '0;
          end
        end
        BUS: begin
          if (wb_ack) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= head_we ? '0 : rd_word;
            retry     <= '0;
            state     <= more ? BUS : IDLE;
          end else if (wb_rty) begin
            if (final_try) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
              retry     <= '0;
              state     <= more ? BUS : IDLE;
            end else begin
              retry <= retry + 1'b1;
              state <= BACKOFF;
            end
          end
        end
        BACKOFF: state <= BUS;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_word_port.sv
// Self-checking bench for wb_word_port: directed scenarios plus a randomized
// run against a queue-based behavioural model.
module tb_wb_word_port;

  localparam int WORD_W    = 16;
  localparam int LINE_W    = 128;
  localparam int ADDR_W    = 16;
  localparam int DEPTH     = 2;
  localparam int MAX_RETRY = 3;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
  } req_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_we = 1'b0;
  logic [15:0]  req_addr = '0;
  logic [15:0]  req_wdata = '0;
  logic [1:0]   req_be = '0;
  logic         rsp_valid;
  logic [15:0]  rsp_rdata;
  logic         rsp_err;
  logic [11:0]  wb_adr;
  logic [127:0] wb_dat_m;
  logic [127:0] wb_dat_s = '0;
  logic [15:0]  wb_sel;
  logic         wb_we;
  logic         wb_stb;
  logic         wb_cyc;
  logic         wb_ack = 1'b0;
  logic         wb_rty = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  req_t mq[$];

  wb_word_port #(
    .WORD_W(WORD_W), .LINE_W(LINE_W), .ADDR_W(ADDR_W),
    .DEPTH(DEPTH), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .wb_adr(wb_adr), .wb_dat_m(wb_dat_m), .wb_dat_s(wb_dat_s),
    .wb_sel(wb_sel), .wb_we(wb_we), .wb_stb(wb_stb), .wb_cyc(wb_cyc),
    .wb_ack(wb_ack), .wb_rty(wb_rty)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] word_of(input logic [127:0] line, input int i);
    return line[i*16 +: 16];
  endfunction

  function automatic logic [127:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic drive_req(input logic we, input logic [15:0] addr,
                           input logic [15:0] wdata, input logic [1:0] be);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req_valid = 1'b0;
    wb_ack = 1'b0;
    wb_rty = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    n_checks++; if (wb_stb !== 1'b0 || wb_cyc !== 1'b0) begin n_fail++; $display("FAIL reset_stb_cyc got=%b%b exp=00", wb_stb, wb_cyc); end
    n_checks++; if (wb_we !== 1'b0 || wb_sel !== 16'h0) begin n_fail++; $display("FAIL reset_we_sel got=%b %h exp=0 0000", wb_we, wb_sel); end
    n_checks++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 16'h0) begin n_fail++; $display("FAIL reset_rsp got=%b %b %h exp=0 0 0000", rsp_valid, rsp_err, rsp_rdata); end
    apply_reset();
  endtask

  task automatic test_read();
    logic [127:0] line;
    drive_req(1'b0, 16'h0036, 16'h0000, 2'b11);
    tick();
    req_valid = 1'b0;
    n_checks++; if (wb_stb !== 1'b1 || wb_cyc !== 1'b1) begin n_fail++; $display("FAIL rd_stb_latency got=%b%b exp=11", wb_stb, wb_cyc); end
    n_checks++; if (wb_adr !== 12'h003) begin n_fail++; $display("FAIL rd_adr got=%h exp=003", wb_adr); end
    n_checks++; if (wb_sel !== 16'h00C0) begin n_fail++; $display("FAIL rd_sel got=%h exp=00c0", wb_sel); end
    n_checks++; if (wb_we !== 1'b0) begin n_fail++; $display("FAIL rd_we got=%b exp=0", wb_we); end
    tick();
    tick();
    n_checks++; if (wb_stb !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rd_wait got stb=%b rsp=%b exp stb=1 rsp=0", wb_stb, rsp_valid); end
    line = rand_line();
    line[63:48] = 16'hBEEF;
    wb_dat_s = line;
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL rd_rsp got=%b err=%b exp=1 err=0", rsp_valid, rsp_err); end
    n_checks++; if (rsp_rdata !== 16'hBEEF) begin n_fail++; $display("FAIL rd_data got=%h exp=beef", rsp_rdata); end
    n_checks++; if (wb_stb !== 1'b0) begin n_fail++; $display("FAIL rd_release got=%b exp=0", wb_stb); end
    tick();
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rd_pulse got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_write();
    drive_req(1'b1, 16'h001E, 16'h1234, 2'b01);
    tick();
    req_valid = 1'b0;
    n_checks++; if (wb_we !== 1'b1 || wb_stb !== 1'b1) begin n_fail++; $display("FAIL wr_we got=%b stb=%b exp=1 1", wb_we, wb_stb); end
    n_checks++; if (wb_sel !== 16'h4000) begin n_fail++; $display("FAIL wr_sel got=%h exp=4000", wb_sel); end
    n_checks++; if (wb_dat_m[127:112] !== 16'h1234) begin n_fail++; $display("FAIL wr_dat got=%h exp=1234", wb_dat_m[127:112]); end
    n_checks++; if (wb_adr !== 12'h001) begin n_fail++; $display("FAIL wr_adr got=%h exp=001", wb_adr); end
    wb_dat_s = rand_line();
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 16'h0) begin n_fail++; $display("FAIL wr_rsp got=%b %b %h exp=1 0 0000", rsp_valid, rsp_err, rsp_rdata); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [127:0] line;
    line = rand_line();
    wb_dat_s = line;
    drive_req(1'b0, 16'h0002, 16'h0, 2'b11);
    tick();
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready1 got=%b exp=1", req_ready); end
    drive_req(1'b0, 16'h0014, 16'h0, 2'b11);
    tick();
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full got=%b exp=0", req_ready); end
    drive_req(1'b1, 16'h0028, 16'hCAFE, 2'b11);
    tick();
    n_checks++; if (req_ready !== 1'b0 || wb_adr !== 12'h000) begin n_fail++; $display("FAIL b2b_hold got ready=%b adr=%h exp 0 000", req_ready, wb_adr); end
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== word_of(line, 1)) begin n_fail++; $display("FAIL b2b_first got=%b %h exp=1 %h", rsp_valid, rsp_rdata, word_of(line, 1)); end
    n_checks++; if (req_ready !== 1'b1 || wb_stb !== 1'b1 || wb_adr !== 12'h001) begin n_fail++; $display("FAIL b2b_second_issue got ready=%b stb=%b adr=%h exp 1 1 001", req_ready, wb_stb, wb_adr); end
    tick();
    req_valid = 1'b0;
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_third_accept got=%b exp=0", req_ready); end
    wb_ack = 1'b1;
    tick();
    n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== word_of(line, 2)) begin n_fail++; $display("FAIL b2b_second got=%b %h exp=1 %h", rsp_valid, rsp_rdata, word_of(line, 2)); end
    n_checks++; if (wb_adr !== 12'h002 || wb_we !== 1'b1 || wb_sel !== 16'h0300) begin n_fail++; $display("FAIL b2b_third_issue got adr=%h we=%b sel=%h exp 002 1 0300", wb_adr, wb_we, wb_sel); end
    tick();
    wb_ack = 1'b0;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 16'h0 || wb_stb !== 1'b0) begin n_fail++; $display("FAIL b2b_third got=%b %h stb=%b exp=1 0000 0", rsp_valid, rsp_rdata, wb_stb); end
    tick();
  endtask

  task automatic test_retry();
    drive_req(1'b0, 16'h0008, 16'h0, 2'b11);
    tick();
    drive_req(1'b1, 16'h0030, 16'h5A5A, 2'b10);
    tick();
    req_valid = 1'b0;
    for (int r = 0; r < 4; r++) begin
      wb_rty = 1'b1;
      tick();
      wb_rty = 1'b0;
      if (r < 3) begin
        n_checks++; if (wb_stb !== 1'b0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rty_backoff%0d got stb=%b rsp=%b exp 0 0", r, wb_stb, rsp_valid); end
        tick();
        n_checks++; if (wb_stb !== 1'b1 || wb_adr !== 12'h000) begin n_fail++; $display("FAIL rty_reissue%0d got stb=%b adr=%h exp 1 000", r, wb_stb, wb_adr); end
      end
    end
    n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 16'h0) begin n_fail++; $display("FAIL rty_err got=%b %b %h exp=1 1 0000", rsp_valid, rsp_err, rsp_rdata); end
    n_checks++; if (wb_stb !== 1'b1 || wb_adr !== 12'h003 || wb_we !== 1'b1 || wb_sel !== 16'h0002) begin n_fail++; $display("FAIL rty_next got stb=%b adr=%h we=%b sel=%h exp 1 003 1 0002", wb_stb, wb_adr, wb_we, wb_sel); end
    wb_ack = 1'b1;
    wb_rty = 1'b1;
    tick();
    wb_ack = 1'b0;
    wb_rty = 1'b0;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL rty_ack_wins got=%b err=%b exp=1 0", rsp_valid, rsp_err); end
    tick();
  endtask

  task automatic test_random(input int cycles);
    req_t        m;
    int          size_before;
    int          retries;
    int          i;
    logic        exp_stb;
    logic        backoff;
    logic        exp_rsp;
    logic        exp_err;
    logic [15:0] exp_rdata;
    logic [15:0] exp_sel;
    logic [127:0] exp_dat;
    apply_reset();
    mq.delete();
    retries = 0;
    exp_stb = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      drive_req(1'($urandom), 16'($urandom), 16'($urandom), 2'($urandom));
      req_valid = ($urandom_range(0, 2) != 0);
      wb_ack = ($urandom_range(0, 3) == 0);
      wb_rty = ($urandom_range(0, 3) == 0);
      wb_dat_s = rand_line();
      size_before = mq.size();
      tick();
      exp_rsp = 1'b0;
      exp_err = 1'b0;
      exp_rdata = 16'h0;
      backoff = 1'b0;
      if (exp_stb) begin
        if (wb_ack) begin
          m = mq.pop_front();
          exp_rsp = 1'b1;
          exp_rdata = m.we ? 16'h0 : word_of(wb_dat_s, (m.addr % 16) / 2);
          retries = 0;
        end else if (wb_rty) begin
          if (retries == MAX_RETRY) begin
            void'(mq.pop_front());
            exp_rsp = 1'b1;
            exp_err = 1'b1;
            retries = 0;
          end else begin
            retries++;
            backoff = 1'b1;
          end
        end
      end
      if (req_valid && size_before < DEPTH) begin
        m.we = req_we; m.addr = req_addr; m.wdata = req_wdata; m.be = req_be;
        mq.push_back(m);
      end
      exp_stb = !backoff && (mq.size() > 0);
      n_checks++; if (rsp_valid !== exp_rsp) begin n_fail++; $display("FAIL rnd_rsp_valid c=%0d got=%b exp=%b", c, rsp_valid, exp_rsp); end
      if (exp_rsp) begin
        n_checks++; if (rsp_err !== exp_err || rsp_rdata !== exp_rdata) begin n_fail++; $display("FAIL rnd_rsp_data c=%0d got=%b %h exp=%b %h", c, rsp_err, rsp_rdata, exp_err, exp_rdata); end
      end
      n_checks++; if (wb_stb !== exp_stb || wb_cyc !== exp_stb) begin n_fail++; $display("FAIL rnd_stb c=%0d got=%b%b exp=%b", c, wb_stb, wb_cyc, exp_stb); end
      n_checks++; if (req_ready !== (mq.size() < DEPTH)) begin n_fail++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, req_ready, mq.size() < DEPTH); end
      if (exp_stb) begin
        m = mq[0];
        i = (m.addr % 16) / 2;
        exp_sel = 16'(m.be) << (2 * i);
        exp_dat = 128'(m.wdata) << (16 * i);
        n_checks++; if (wb_adr !== 12'(m.addr / 16) || wb_we !== m.we || wb_sel !== exp_sel || wb_dat_m !== exp_dat) begin n_fail++; $display("FAIL rnd_bus c=%0d got adr=%h we=%b sel=%h exp adr=%h we=%b sel=%h", c, wb_adr, wb_we, wb_sel, 12'(m.addr / 16), m.we, exp_sel); end
      end else begin
        n_checks++; if (wb_sel !== 16'h0 || wb_we !== 1'b0) begin n_fail++; $display("FAIL rnd_idle_bus c=%0d got sel=%h we=%b exp 0000 0", c, wb_sel, wb_we); end
      end
    end
    req_valid = 1'b0;
    wb_ack = 1'b0;
    wb_rty = 1'b0;
  endtask

  task automatic test_mid_reset();
    apply_reset();
    tick();
    drive_req(1'b0, 16'h0010, 16'h0, 2'b11);
    tick();
    drive_req(1'b1, 16'h0020, 16'h7777, 2'b11);
    tick();
    req_valid = 1'b0;
    n_checks++; if (wb_stb !== 1'b1 || req_ready !== 1'b0) begin n_fail++; $display("FAIL mrst_setup got stb=%b ready=%b exp 1 0", wb_stb, req_ready); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (wb_stb !== 1'b0 || wb_cyc !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL mrst_async got stb=%b cyc=%b ready=%b exp 0 0 1", wb_stb, wb_cyc, req_ready); end
    tick();
    rst_n = 1'b1;
    wb_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++; if (rsp_valid !== 1'b0 || wb_stb !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL mrst_after%0d got rsp=%b stb=%b ready=%b exp 0 0 1", k, rsp_valid, wb_stb, req_ready); end
    end
    wb_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_retry();
    test_random(400);
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
